// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches words from
// instruction memory over a req/ack handshake and hands each instruction to
// the decoder over a valid/ready handshake. The next PC is resolved from the
// decoder's jump/pcsrc decision on the cycle the instruction is consumed.
module fetch_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcplus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             pcsrc,
    input  logic             jump
);

    // First fetch address with the byte-offset bits cleared.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // IDLE gives one dead cycle after reset so a stale ack cannot be taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_w;
    logic [31:0] branch_off_w;
    logic [31:0] next_pc_w;

    // Outputs come only from registers or decoded state.
    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pcplus4     = pcplus4_w;

    assign pcplus4_w    = pc_q + 32'd4;
    assign branch_off_w = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Next fetch address: jump has priority over a taken branch; all modulo 2^32.
    always_comb begin
        next_pc_w = pcplus4_w;
        if (jump) begin
            next_pc_w = {pcplus4_w[31:28], instr_q[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc_w = pcplus4_w + branch_off_w;
        end
    end

    // Next-state logic for the fetch handshake and the captured instruction.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    fetch_pc_d = next_pc_w;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC_ALIGNED;
            pc_q       <= RESET_PC_ALIGNED;
            instr_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

endmodule
